// File: rtl/jpeg_ctrl_pkg.sv
// Shared types and constants for the JPEG stream sequencer.
// Holds the FSM state encoding, JPEG marker bytes and default parameter values.
package jpeg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_SEND,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [7:0] MARKER_FF  = 8'hFF;
  localparam logic [7:0] MARKER_D9  = 8'hD9;
  localparam logic [7:0] FLUSH_BYTE = 8'h00;

  localparam int DEF_ADDR_W         = 19;
  localparam int DEF_FLUSH_BYTES    = 200;
  localparam int DEF_STALL_CYCLES   = 1000000;
  localparam int DEF_TIMEOUT_CYCLES = 20000000;

  // Wide enough for the largest default watchdog limit.
  localparam int WD_W = 32;

endpackage

// File: rtl/ctrl_watchdog.sv
// Clearable up-counter; hit flags the cycle that is the LIMIT-th enabled cycle
// since the last clear, so the owner can act on the following edge.
module ctrl_watchdog
  import jpeg_ctrl_pkg::*;
#(
  parameter int LIMIT = DEF_STALL_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [WD_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !hit) begin
      count <= count + WD_W'(1);
    end
  end

  assign hit = enable && (count == WD_W'(LIMIT - 1));

endmodule

// File: rtl/jpeg_stream_ctrl.sv
// Feeds a JPEG file from byte-wide memory into the parser, appends the zero
// flush, then waits for the frame's pixels (or a watchdog) before reporting done.
module jpeg_stream_ctrl
  import jpeg_ctrl_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int FLUSH_BYTES    = DEF_FLUSH_BYTES,
  parameter int STALL_CYCLES   = DEF_STALL_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   src_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        byte_in,
  output logic              byte_valid,
  input  logic              parser_ready,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  input  logic              rgb_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              eoi_seen,
  output logic [31:0]       pixel_cnt
);

  localparam int             FLUSH_W = $clog2(FLUSH_BYTES + 1);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  state_t               state, state_nxt;
  logic [ADDR_W:0]      index, len_q, index_inc;
  logic [7:0]           byte_q;
  logic                 prev_ff;
  logic [31:0]          total_q;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 launch, accept, feeding, is_eoi, frame_complete;
  logic                 stall_hit, drain_hit;

  assign launch         = start && (state == ST_IDLE || state == ST_DONE);
  assign feeding        = (state == ST_SEND) || (state == ST_FLUSH);
  assign accept         = byte_valid && parser_ready;
  assign is_eoi         = prev_ff && (byte_q == MARKER_D9);
  assign index_inc      = index + IDX_ONE;
  // A zero total means the header has not been parsed yet.
  assign frame_complete = (total_q != '0) && (pixel_cnt >= total_q);

  ctrl_watchdog #(.LIMIT(STALL_CYCLES)) u_stall_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (!feeding || parser_ready),
    .enable (feeding && !parser_ready),
    .hit    (stall_hit)
  );

  ctrl_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_drain_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_DRAIN),
    .enable (state == ST_DRAIN),
    .hit    (drain_hit)
  );

  // NOTE: next state gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = (src_len == '0) ? ST_FLUSH : ST_RD;
      ST_RD:    state_nxt = ST_CAP;
      ST_CAP:   state_nxt = ST_SEND;
      ST_SEND: begin
        if (stall_hit)                             state_nxt = ST_DONE;
        else if (accept && (is_eoi || index_inc == len_q)) state_nxt = ST_FLUSH;
        else if (accept)                           state_nxt = ST_RD;
      end
      ST_FLUSH: begin
        if (stall_hit) state_nxt = ST_DONE;
        else if (accept && flush_cnt == FLUSH_W'(FLUSH_BYTES - 1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (frame_complete || drain_hit) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      len_q     <= '0;
      byte_q    <= FLUSH_BYTE;
      prev_ff   <= 1'b0;
      total_q   <= '0;
      flush_cnt <= '0;
      pixel_cnt <= '0;
      timeout   <= 1'b0;
      eoi_seen  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        index     <= '0;
        len_q     <= src_len;
        prev_ff   <= 1'b0;
        total_q   <= '0;
        flush_cnt <= '0;
        pixel_cnt <= '0;
        timeout   <= 1'b0;
        eoi_seen  <= 1'b0;
      end else begin
        if (state == ST_CAP) byte_q <= mem_rdata;
        if (state == ST_SEND && accept) begin
          index   <= index_inc;
          prev_ff <= (byte_q == MARKER_FF);
          if (is_eoi) eoi_seen <= 1'b1;
        end
        if (state == ST_FLUSH && accept) flush_cnt <= flush_cnt + FLUSH_W'(1);
        if (stall_hit || (state == ST_DRAIN && drain_hit && !frame_complete)) timeout <= 1'b1;
        if (busy && total_q == '0 && img_width != '0 && img_height != '0)
          total_q <= 32'(img_width) * 32'(img_height);
        if (busy && rgb_valid && pixel_cnt != '1) pixel_cnt <= pixel_cnt + 32'd1;
      end
    end
  end

  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign mem_rd     = (state == ST_RD);
  assign mem_addr   = index[ADDR_W-1:0];
  assign byte_valid = feeding;
  assign byte_in    = (state == ST_FLUSH) ? FLUSH_BYTE : byte_q;

endmodule

// File: tb/tb_jpeg_stream_ctrl.sv
// Directed bench for jpeg_stream_ctrl: byte-wide memory model, accepted-byte
// monitor, and one task per scenario with hand-computed expectations.
module tb_jpeg_stream_ctrl;

  localparam int ADDR_W = 19;

  logic              clk = 1'b0;
  logic              rst, start, parser_ready, rgb_valid;
  logic [ADDR_W:0]   src_len;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic [15:0]       img_width, img_height;
  logic              busy, done, timeout, eoi_seen;
  logic [31:0]       pixel_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  logic [7:0] mem [16];
  logic [7:0] s_eoi   [10] = '{8'hFF, 8'hD8, 8'h12, 8'h34, 8'hFF, 8'hD9, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] s_plain [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  logic [7:0] acc_byte[$];
  int         acc_cyc[$];
  int         rd_addr[$];
  int         stab_err = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  jpeg_stream_ctrl #(
    .ADDR_W(ADDR_W), .FLUSH_BYTES(200), .STALL_CYCLES(50), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .src_len(src_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .byte_in(byte_in), .byte_valid(byte_valid), .parser_ready(parser_ready),
    .img_width(img_width), .img_height(img_height), .rgb_valid(rgb_valid),
    .busy(busy), .done(done), .timeout(timeout), .eoi_seen(eoi_seen),
    .pixel_cnt(pixel_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory: one-cycle read latency, every read address logged.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= (mem_addr < ADDR_W'(16)) ? mem[mem_addr[3:0]] : 8'h00;
      rd_addr.push_back(int'(mem_addr));
    end
  end

  // Accepted-byte log plus hold-stability tracking while the parser stalls.
  always @(negedge clk) begin
    if (byte_valid && parser_ready) begin
      acc_byte.push_back(byte_in);
      acc_cyc.push_back(cyc);
    end
    if (prev_hold && byte_valid && byte_in !== prev_byte) stab_err = stab_err + 1;
    prev_hold = byte_valid && !parser_ready;
    prev_byte = byte_in;
  end

  task automatic load_mem(input bit plain);
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    if (plain) for (int i = 0; i < 6; i++)  mem[i] = s_plain[i];
    else       for (int i = 0; i < 10; i++) mem[i] = s_eoi[i];
  endtask

  // Cycle 0 is the cycle in which start is high; returns at cycle 1.
  task automatic start_frame(input logic [ADDR_W:0] len);
    @(posedge clk); #1;
    src_len = len;
    start   = 1'b1;
    t0      = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, output bit ok);
    int k = 0;
    while (acc_byte.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    ok = (acc_byte.size() >= n);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin @(posedge clk); #1; k++; end
    ok = (done === 1'b1);
  endtask

  task automatic pulse_rgb(input int n);
    repeat (n) begin
      rgb_valid = 1'b1; @(posedge clk); #1;
      rgb_valid = 1'b0; @(posedge clk); #1;
    end
  endtask

  function automatic int flush_nonzero(input int from, input int n);
    int nz = 0;
    for (int i = from; i < from + n && i < acc_byte.size(); i++) if (acc_byte[i] != 8'h00) nz++;
    return nz;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%0b exp=0", byte_valid); end
    checks++; if (mem_rd !== 1'b0)     begin failures++; $display("FAIL reset_mem_rd got=%0b exp=0", mem_rd); end
    checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (timeout !== 1'b0)    begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
    checks++; if (eoi_seen !== 1'b0)   begin failures++; $display("FAIL reset_eoi got=%0b exp=0", eoi_seen); end
    checks++; if (byte_in !== 8'h00)   begin failures++; $display("FAIL reset_byte_in got=%02h exp=00", byte_in); end
    checks++; if (mem_addr !== '0)     begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (pixel_cnt !== 32'd0) begin failures++; $display("FAIL reset_pixel_cnt got=%0d exp=0", pixel_cnt); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_eoi_frame();
    bit ok; int base;
    load_mem(1'b0);
    parser_ready = 1'b1; img_width = 16'd0; img_height = 16'd0;
    base = acc_byte.size();
    start_frame(6);
    wait_acc(base + 2, 50, ok);
    img_width = 16'd2; img_height = 16'd2;
    wait_acc(base + 100, 300, ok);
    src_len = '0; start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_acc(base + 206, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL eoi_accept_count got=%0d exp=206", acc_byte.size() - base); end
    pulse_rgb(4);
    wait_done(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL eoi_done got=%0b exp=1", done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (acc_byte[base+i] !== s_eoi[i]) begin failures++; $display("FAIL eoi_byte%0d got=%02h exp=%02h", i, acc_byte[base+i], s_eoi[i]); end
      checks++;
      if (acc_cyc[base+i] - t0 !== 3 * (i + 1)) begin failures++; $display("FAIL eoi_cycle%0d got=%0d exp=%0d", i, acc_cyc[base+i] - t0, 3 * (i + 1)); end
    end
    checks++; if (flush_nonzero(base + 6, 200) !== 0) begin failures++; $display("FAIL eoi_flush_zero got=%0d exp=0", flush_nonzero(base + 6, 200)); end
    checks++; if (acc_cyc[base+205] - t0 !== 218) begin failures++; $display("FAIL eoi_last_flush_cycle got=%0d exp=218", acc_cyc[base+205] - t0); end
    checks++; if (acc_byte.size() - base !== 206) begin failures++; $display("FAIL eoi_total_bytes got=%0d exp=206", acc_byte.size() - base); end
    checks++; if (eoi_seen !== 1'b1) begin failures++; $display("FAIL eoi_seen got=%0b exp=1", eoi_seen); end
    checks++; if (timeout !== 1'b0)  begin failures++; $display("FAIL eoi_timeout got=%0b exp=0", timeout); end
    checks++; if (pixel_cnt !== 32'd4) begin failures++; $display("FAIL eoi_pixel_cnt got=%0d exp=4", pixel_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL eoi_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_early_eoi();
    bit ok; int base, rbase, high_reads;
    load_mem(1'b0);
    parser_ready = 1'b1; img_width = 16'd0; img_height = 16'd0;
    base = acc_byte.size(); rbase = rd_addr.size();
    start_frame(10);
    wait_acc(base + 206, 500, ok);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL early_done got=%0b exp=1", done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (acc_byte[base+i] !== s_eoi[i]) begin failures++; $display("FAIL early_byte%0d got=%02h exp=%02h", i, acc_byte[base+i], s_eoi[i]); end
    end
    checks++; if (acc_byte.size() - base !== 206) begin failures++; $display("FAIL early_total_bytes got=%0d exp=206", acc_byte.size() - base); end
    high_reads = 0;
    for (int i = rbase; i < rd_addr.size(); i++) if (rd_addr[i] >= 6) high_reads++;
    checks++; if (high_reads !== 0) begin failures++; $display("FAIL early_reads_past_eoi got=%0d exp=0", high_reads); end
    checks++; if (rd_addr.size() - rbase !== 6) begin failures++; $display("FAIL early_read_count got=%0d exp=6", rd_addr.size() - rbase); end
    checks++; if (eoi_seen !== 1'b1) begin failures++; $display("FAIL early_eoi got=%0b exp=1", eoi_seen); end
    checks++; if (timeout !== 1'b1)  begin failures++; $display("FAIL early_timeout got=%0b exp=1", timeout); end
  endtask

  task automatic test_ready_toggle();
    int base, rbase, stab0, k;
    load_mem(1'b1);
    parser_ready = 1'b0; img_width = 16'd0; img_height = 16'd0;
    base = acc_byte.size(); rbase = rd_addr.size(); stab0 = stab_err;
    start_frame(6);
    k = 0;
    while (done !== 1'b1 && k < 3000) begin
      parser_ready = (cyc % 4 == 0);
      @(posedge clk); #1; k++;
    end
    parser_ready = 1'b1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL toggle_done got=%0b exp=1", done); end
    checks++; if (acc_byte.size() - base !== 206) begin failures++; $display("FAIL toggle_total_bytes got=%0d exp=206", acc_byte.size() - base); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (acc_byte[base+i] !== s_plain[i]) begin failures++; $display("FAIL toggle_byte%0d got=%02h exp=%02h", i, acc_byte[base+i], s_plain[i]); end
    end
    checks++; if (flush_nonzero(base + 6, 200) !== 0) begin failures++; $display("FAIL toggle_flush_zero got=%0d exp=0", flush_nonzero(base + 6, 200)); end
    checks++; if (stab_err - stab0 !== 0) begin failures++; $display("FAIL toggle_hold_stable got=%0d exp=0", stab_err - stab0); end
    checks++; if (rd_addr.size() - rbase !== 6) begin failures++; $display("FAIL toggle_read_count got=%0d exp=6", rd_addr.size() - rbase); end
    checks++; if (eoi_seen !== 1'b0) begin failures++; $display("FAIL toggle_eoi got=%0b exp=0", eoi_seen); end
  endtask

  task automatic test_stall_watchdog();
    bit ok; int base, drop_lat;
    load_mem(1'b0);
    parser_ready = 1'b1; img_width = 16'd0; img_height = 16'd0;
    base = acc_byte.size();
    start_frame(6);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (byte_valid !== 1'b1 || byte_in !== 8'h12) begin failures++; $display("FAIL stall_third_byte got=%0b/%02h exp=1/12", byte_valid, byte_in); end
    parser_ready = 1'b0;
    wait_done(200, ok);
    drop_lat = cyc - t0;
    checks++; if (!ok) begin failures++; $display("FAIL stall_done got=%0b exp=1", done); end
    checks++; if (drop_lat !== 59) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=59", drop_lat); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL stall_timeout got=%0b exp=1", timeout); end
    repeat (3) begin
      checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL stall_valid_low got=%0b exp=0", byte_valid); end
      @(posedge clk); #1;
    end
    checks++; if (acc_byte.size() - base !== 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", acc_byte.size() - base); end
    checks++; if (eoi_seen !== 1'b0) begin failures++; $display("FAIL stall_eoi got=%0b exp=0", eoi_seen); end
    parser_ready = 1'b1;
  endtask

  task automatic test_empty_stream();
    bit ok; int base, rbase, lat;
    parser_ready = 1'b1; img_width = 16'd0; img_height = 16'd0;
    base = acc_byte.size(); rbase = rd_addr.size();
    start_frame(0);
    wait_done(500, ok);
    lat = cyc - t0;
    checks++; if (!ok) begin failures++; $display("FAIL empty_done got=%0b exp=1", done); end
    checks++; if (lat !== 301) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=301", lat); end
    checks++; if (acc_byte.size() - base !== 200) begin failures++; $display("FAIL empty_flush_count got=%0d exp=200", acc_byte.size() - base); end
    checks++; if (acc_cyc[base] - t0 !== 1) begin failures++; $display("FAIL empty_first_flush got=%0d exp=1", acc_cyc[base] - t0); end
    checks++; if (acc_cyc[base+199] - t0 !== 200) begin failures++; $display("FAIL empty_last_flush got=%0d exp=200", acc_cyc[base+199] - t0); end
    checks++; if (flush_nonzero(base, 200) !== 0) begin failures++; $display("FAIL empty_flush_zero got=%0d exp=0", flush_nonzero(base, 200)); end
    checks++; if (rd_addr.size() - rbase !== 0) begin failures++; $display("FAIL empty_reads got=%0d exp=0", rd_addr.size() - rbase); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL empty_timeout got=%0b exp=1", timeout); end
    checks++; if (pixel_cnt !== 32'd0) begin failures++; $display("FAIL empty_pixel_cnt got=%0d exp=0", pixel_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok; int base;
    load_mem(1'b0);
    parser_ready = 1'b1; img_width = 16'd0; img_height = 16'd0;
    base = acc_byte.size();
    start_frame(6);
    wait_acc(base + 20, 200, ok);
    pulse_rgb(3);
    checks++; if (pixel_cnt !== 32'd3) begin failures++; $display("FAIL b2b_pre_pixels got=%0d exp=3", pixel_cnt); end
    checks++; if (eoi_seen !== 1'b1)   begin failures++; $display("FAIL b2b_pre_eoi got=%0b exp=1", eoi_seen); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL b2b_rst_busy got=%0b exp=0", busy); end
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL b2b_rst_valid got=%0b exp=0", byte_valid); end
    checks++; if (eoi_seen !== 1'b0)   begin failures++; $display("FAIL b2b_rst_eoi got=%0b exp=0", eoi_seen); end
    checks++; if (pixel_cnt !== 32'd0) begin failures++; $display("FAIL b2b_rst_pixels got=%0d exp=0", pixel_cnt); end
    checks++; if (byte_in !== 8'h00)   begin failures++; $display("FAIL b2b_rst_byte_in got=%02h exp=00", byte_in); end
    checks++; if (done !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL b2b_rst_flags got=%0b%0b exp=00", done, timeout); end
    rst = 1'b0;
    base = acc_byte.size();
    start_frame(6);
    wait_acc(base + 2, 50, ok);
    img_width = 16'd2; img_height = 16'd2;
    wait_acc(base + 206, 400, ok);
    pulse_rgb(4);
    wait_done(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done got=%0b exp=1", done); end
    checks++; if (pixel_cnt !== 32'd4) begin failures++; $display("FAIL b2b_pixel_cnt got=%0d exp=4", pixel_cnt); end
    checks++; if (timeout !== 1'b0)    begin failures++; $display("FAIL b2b_timeout got=%0b exp=0", timeout); end
    checks++; if (acc_byte.size() - base !== 206) begin failures++; $display("FAIL b2b_total_bytes got=%0d exp=206", acc_byte.size() - base); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_len = '0; parser_ready = 1'b1; rgb_valid = 1'b0;
    img_width = 16'd0; img_height = 16'd0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_eoi_frame();
    test_early_eoi();
    test_ready_toggle();
    test_stall_watchdog();
    test_empty_stream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jpeg_stream_ctrl.md
# jpeg_stream_ctrl

Hardware sequencer that feeds a JPEG file from a byte-wide source memory into the decoder's parser, then drives the end-of-stream flush and watches the pixel output until the frame completes. It sits between the image ROM/buffer and `jpeg_decoder_top`, which contains the parser. It makes whole-frame decode self-contained in hardware and reports done, timeout and pixel count to the system.

## Interface
- `ADDR_W`, 19: source address width (512 KB).
- `FLUSH_BYTES`, 200: number of 0x00 bytes appended after the stream.
- `STALL_CYCLES`, 1000000: maximum consecutive cycles `parser_ready` may stay low during SEND/FLUSH.
- `TIMEOUT_CYCLES`, 20000000: maximum cycles spent in DRAIN.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; begins a frame; ignored unless in IDLE or DONE.
- `src_len` in ADDR_W+1: file length in bytes; sampled on `start`.
- `mem_rd` out 1: read strobe; data returns one cycle later.
- `mem_addr` out ADDR_W: read address.
- `mem_rdata` in 8: read data.
- `byte_in` out 8: byte to the parser.
- `byte_valid` out 1: byte offered to the parser.
- `parser_ready` in 1: parser accepts a byte when it and `byte_valid` are both high.
- `img_width` in 16, `img_height` in 16: frame dimensions from the parser; zero until the header is parsed.
- `rgb_valid` in 1: one decoded pixel per high cycle.
- `busy` out 1: state is not IDLE and not DONE.
- `done` out 1: level; set in DONE.
- `timeout` out 1: qualifies `done`; set when the frame ended on a watchdog.
- `eoi_seen` out 1: an FF D9 pair was sent.
- `pixel_cnt` out 32: pixels counted this frame.

## Operation
- States: IDLE → RD → CAP → SEND → (RD | FLUSH) → DRAIN → DONE.
- IDLE/DONE: on `start`, clear `pixel_cnt`, `timeout`, `eoi_seen`, byte index, total and watchdogs.
  - `src_len`==0 → go to FLUSH.
  - Otherwise → go to RD.
- RD: `mem_rd`=1, `mem_addr`=index → go to CAP.
- CAP: register `mem_rdata` into `byte_in` → go to SEND.
- SEND: `byte_valid`=1, holding `byte_in` until accepted. On acceptance, increment index.
  - If the byte completes FF D9 (previous accepted byte FF, this one D9): set `eoi_seen` → go to FLUSH.
  - Else if index == `src_len` → go to FLUSH.
  - Else → go to RD.
- FLUSH: `byte_in`=0x00, `byte_valid`=1. Count accepted bytes; after the FLUSH_BYTES-th acceptance → go to DRAIN.
- DRAIN: `byte_valid`=0.
  - When total≠0 and `pixel_cnt` ≥ total → go to DONE.
  - When the drain counter reaches TIMEOUT_CYCLES → set `timeout`, go to DONE.
- Stall watchdog in SEND/FLUSH: resets on any cycle `parser_ready`=1. When it reaches STALL_CYCLES → set `timeout`, go to DONE, drop `byte_valid`.
- Total pixels: latched = `img_width`×`img_height` (32-bit product) on the first busy cycle where both inputs are nonzero; never re-latched within a frame.
- `pixel_cnt`: increments on `rgb_valid` in every busy state; saturates at 0xFFFFFFFF; held in DONE.
- `start` while busy is ignored.
- `rgb_valid` in the same cycle as the DRAIN exit is counted.

## Timing
- Reset values: `byte_valid`, `mem_rd`, `done`, `timeout`, `eoi_seen` = 0; `byte_in`=0x00; `mem_addr`=0; `pixel_cnt`=0; state IDLE.
- `rst` asserted mid-frame: IDLE on the next edge, `byte_valid` low that edge.
- Source byte throughput is at most one per 3 cycles (RD, CAP, SEND with ready high).
- First `byte_valid` is 3 cycles after the `start` edge.
- FLUSH sustains one byte per cycle while ready.
- `done` rises on the edge following the DONE transition condition; held until the next `start` or `rst`.
- `byte_in` is stable whenever `byte_valid`=1 and `parser_ready`=0.

## Structure
- Shared package `jpeg_ctrl_pkg`:
  - State enum.
  - Marker constants FF, D9.
  - FLUSH_BYTE = 0x00.
  - Default parameter values.
- One sub-module, `ctrl_watchdog`: clearable up-counter with terminal-count compare. Instantiated twice, once for the stall watchdog and once for the drain timeout.

## Test plan
- src_len=6, bytes FF D8 12 34 FF D9, ready always 1, width=2, height=2 set after the 2nd byte, 4 `rgb_valid` pulses in DRAIN → 6 bytes appear at cycles 3,6,…,18, then 200 zeros, `eoi_seen`=1, `done`=1, `timeout`=0, `pixel_cnt`=4.
- Same stream but src_len=10 with EOI at index 5 → only 6 source bytes sent, addresses 6–9 never read.
- `parser_ready` toggling 1-of-4 cycles → every byte delivered once, `byte_in` stable while stalled, order preserved.
- STALL_CYCLES=50, ready held low from the 3rd byte → `done`=1, `timeout`=1 exactly 50 cycles after ready drops; `byte_valid`=0 thereafter.
- src_len=0, width/height never set, TIMEOUT_CYCLES=100 → 200 flush bytes, then `timeout`=1 after 100 DRAIN cycles, `pixel_cnt`=0.
- `rst` pulsed during FLUSH, then `start` again → IDLE next edge, outputs at reset values, second frame completes with `pixel_cnt` restarted from 0.
